bpu_table_sched: RTL and testbench

BPU_TABLE_SCHED -- requirements
Module: bpu_table_sched

---
 rtl/bpu_table_sched_if.sv | 32 +++
 rtl/bpu_table_sched.sv | 200 ++++++++++++++++++++
 tb/tb_bpu_table_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_table_sched_if.sv
// Lookup and update handshake bundle between the fetch/resolve front end
// and the branch-prediction table scheduler.
interface bpu_table_sched_if #(
  parameter int unsigned IDX_W = 10
);
  // Lookup channel
  logic             lk_req;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_gnt;
  logic             lk_valid;
  logic [1:0]       lk_cnt;
  logic             lk_taken;

  // Update channel
  logic             upd_req;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_oldcnt;
  logic             upd_taken;
  logic             upd_ready;

  // Front end side
  modport master (
    output lk_req, lk_idx, upd_req, upd_idx, upd_oldcnt, upd_taken,
    input  lk_gnt, lk_valid, lk_cnt, lk_taken, upd_ready
  );

  // Scheduler side
  modport slave (
    input  lk_req, lk_idx, upd_req, upd_idx, upd_oldcnt, upd_taken,
    output lk_gnt, lk_valid, lk_cnt, lk_taken, upd_ready
  );
endinterface

// File: rtl/bpu_table_sched.sv
// Branch predictor pattern-table scheduler: clears the table after reset,
// then arbitrates a single-port table between lookups and queued counter
// updates, forwarding pending updates to lookups and bounding update starvation.
module bpu_table_sched #(
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  bpu_table_sched_if.slave bus,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic             stallreq
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_addr_q, init_addr_d;

  logic [IDX_W-1:0] q_idx_q [QDEPTH];
  logic [IDX_W-1:0] q_idx_d [QDEPTH];
  logic [1:0]       q_cnt_q [QDEPTH];
  logic [1:0]       q_cnt_d [QDEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic             lk_valid_q, lk_valid_d;
  logic             fwd_hit_q, fwd_hit_d;
  logic [1:0]       fwd_cnt_q, fwd_cnt_d;
  logic [IDX_W-1:0] tbl_addr_q;
  logic [1:0]       tbl_wdata_q;

  logic             q_empty;
  logic             q_full;
  logic             force_deq;
  logic             do_deq;
  logic             do_enq;
  logic             lk_gnt_w;
  logic             upd_ready_w;
  logic [1:0]       upd_newcnt;
  logic [1:0]       lk_cnt_w;

  assign q_empty     = (count_q == '0);
  assign q_full      = (count_q == CW'(QDEPTH));
  assign force_deq   = q_full || ((starve_q == SW'(STARVE_MAX)) && !q_empty);
  assign upd_ready_w = (state_q == S_RUN) && !q_full;
  assign do_enq      = bus.upd_req && upd_ready_w;

  // Saturating 2-bit counter step for the incoming update
  always_comb begin
    upd_newcnt = bus.upd_oldcnt;
    if (bus.upd_taken) begin
      if (bus.upd_oldcnt != 2'b11) upd_newcnt = bus.upd_oldcnt + 2'd1;
    end else begin
      if (bus.upd_oldcnt != 2'b00) upd_newcnt = bus.upd_oldcnt - 2'd1;
    end
  end

  // FSM next state and per-cycle table operation select
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    lk_gnt_w    = 1'b0;
    do_deq      = 1'b0;
    tbl_en      = 1'b0;
    tbl_we      = 1'b0;
    tbl_addr    = tbl_addr_q;
    tbl_wdata   = tbl_wdata_q;
    // No table access while reset is held, so queued updates are dropped unwritten
    if (rst) begin
      unique case (state_q)
        S_INIT: begin
          tbl_en      = 1'b1;
          tbl_we      = 1'b1;
          tbl_addr    = init_addr_q;
          tbl_wdata   = 2'b00;
          init_addr_d = init_addr_q + IDX_W'(1);
          if (init_addr_q == '1) state_d = S_RUN;
        end
        S_RUN: begin
          if (force_deq) begin
            do_deq = 1'b1;
          end else if (bus.lk_req) begin
            lk_gnt_w = 1'b1;
            tbl_en   = 1'b1;
            tbl_addr = bus.lk_idx;
          end else if (!q_empty) begin
            do_deq = 1'b1;
          end
          if (do_deq) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = q_idx_q[head_q];
            tbl_wdata = q_cnt_q[head_q];
          end
        end
        default: ;
      endcase
    end
  end

  // Update queue bookkeeping, starvation counter and lookup forwarding capture
  always_comb begin
    q_idx_d    = q_idx_q;
    q_cnt_d    = q_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    lk_valid_d = lk_gnt_w;
    fwd_hit_d  = 1'b0;
    fwd_cnt_d  = 2'b00;

    if (do_enq) begin
      q_idx_d[tail_q] = bus.upd_idx;
      q_cnt_d[tail_q] = upd_newcnt;
      tail_d          = tail_q + PW'(1);
    end
    if (do_deq) head_d = head_q + PW'(1);

    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (do_deq || q_empty) begin
      starve_d = '0;
    end else if (lk_gnt_w && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end

    // Walk oldest to youngest so the youngest matching entry wins
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if ((i < 32'(count_q)) && (q_idx_q[head_q + PW'(i)] == bus.lk_idx)) begin
        fwd_hit_d = 1'b1;
        fwd_cnt_d = q_cnt_q[head_q + PW'(i)];
      end
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      lk_valid_q  <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_cnt_q   <= 2'b00;
      tbl_addr_q  <= '0;
      tbl_wdata_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      lk_valid_q  <= lk_valid_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_cnt_q   <= fwd_cnt_d;
      tbl_addr_q  <= tbl_addr;
      tbl_wdata_q <= tbl_wdata;
    end
  end

  // Queue payload storage; occupancy is tracked by count_q so no reset needed
  always_ff @(posedge clk) begin
    q_idx_q <= q_idx_d;
    q_cnt_q <= q_cnt_d;
  end

  assign lk_cnt_w = lk_valid_q ? (fwd_hit_q ? fwd_cnt_q : tbl_rdata) : 2'b00;

  assign bus.lk_gnt    = lk_gnt_w;
  assign bus.lk_valid  = lk_valid_q;
  assign bus.lk_cnt    = lk_cnt_w;
  assign bus.lk_taken  = lk_cnt_w[1];
  assign bus.upd_ready = upd_ready_w;
  assign stallreq      = (state_q == S_INIT) || (bus.lk_req && !lk_gnt_w);

endmodule

// File: tb/tb_bpu_table_sched.sv
// Directed bench for bpu_table_sched: table-driven RUN-phase vectors plus
// hand sequences for clear sweep, starvation, full queue, forwarding and reset.
module tb_bpu_table_sched;
  localparam int unsigned IDX_W = 10;
  localparam int unsigned NENT  = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tbl_en, tbl_we, stallreq;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata = 2'b00;
  logic [1:0]       mem [NENT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single-port table model, one-cycle read latency
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  bpu_table_sched_if #(.IDX_W(IDX_W)) bus();

  bpu_table_sched #(
    .IDX_W(IDX_W),
    .QDEPTH(4),
    .STARVE_MAX(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tbl_en   (tbl_en),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata),
    .stallreq (stallreq)
  );

  typedef struct {
    logic             lk_req;
    logic [IDX_W-1:0] lk_idx;
    logic             upd_req;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       old;
    logic             taken;
    logic             gnt, en, we;
    logic [IDX_W-1:0] addr;
    logic [1:0]       wdata;
    logic             valid;
    logic [1:0]       cnt;
    logic             stall;
    logic             ready;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mkv(input int lr, input int li, input int ur, input int ui,
                               input int od, input int tk, input int g, input int e,
                               input int w, input int a, input int wd, input int v,
                               input int c, input int s, input int r);
    vec_t x;
    x.lk_req = 1'(lr); x.lk_idx = IDX_W'(li); x.upd_req = 1'(ur); x.upd_idx = IDX_W'(ui);
    x.old = 2'(od); x.taken = 1'(tk); x.gnt = 1'(g); x.en = 1'(e); x.we = 1'(w);
    x.addr = IDX_W'(a); x.wdata = 2'(wd); x.valid = 1'(v); x.cnt = 2'(c);
    x.stall = 1'(s); x.ready = 1'(r);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int lr, input int li, input int ur, input int ui,
                       input int od, input int tk);
    bus.lk_req     = 1'(lr);
    bus.lk_idx     = IDX_W'(li);
    bus.upd_req    = 1'(ur);
    bus.upd_idx    = IDX_W'(ui);
    bus.upd_oldcnt = 2'(od);
    bus.upd_taken  = 1'(tk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a full ascending clear sweep starting this cycle, then an idle RUN cycle
  task automatic init_sweep(input string tag);
    int bad = 0;
    int first_bad = -1;
    drive(1, 3, 1, 3, 1, 1);
    for (int i = 0; i < int'(NENT); i++) begin
      @(negedge clk);
      if (!(tbl_en === 1'b1 && tbl_we === 1'b1 && tbl_addr === IDX_W'(i) &&
            tbl_wdata === 2'b00 && stallreq === 1'b1 && bus.upd_ready === 1'b0 &&
            bus.lk_gnt === 1'b0)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    check({tag, "_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, "_first_bad"}, 32'(first_bad), 32'hffff_ffff);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check({tag, "_run_ready"}, 32'(bus.upd_ready), 32'd1);
    check({tag, "_run_stall"}, 32'(stallreq), 32'd0);
    check({tag, "_run_idle_en"}, 32'(tbl_en), 32'd0);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mkv(1, 5, 0, 0, 0, 0,  1, 1, 0, 5, 0,  0, 0,  0, 1);
    vt[1] = mkv(0, 0, 1, 5, 1, 1,  0, 0, 0, 5, 0,  1, 0,  0, 1);
    vt[2] = mkv(1, 5, 0, 0, 0, 0,  1, 1, 0, 5, 0,  0, 0,  0, 1);
    vt[3] = mkv(0, 0, 0, 0, 0, 0,  0, 1, 1, 5, 2,  1, 2,  0, 1);
    vt[4] = mkv(1, 5, 0, 0, 0, 0,  1, 1, 0, 5, 2,  0, 0,  0, 1);
    vt[5] = mkv(0, 0, 1, 7, 3, 1,  0, 0, 0, 5, 2,  1, 2,  0, 1);
    vt[6] = mkv(0, 0, 1, 9, 0, 0,  0, 1, 1, 7, 3,  0, 0,  0, 1);
    vt[7] = mkv(0, 0, 0, 0, 0, 0,  0, 1, 1, 9, 0,  0, 0,  0, 1);
    vt[8] = mkv(1, 7, 0, 0, 0, 0,  1, 1, 0, 7, 0,  0, 0,  0, 1);
    vt[9] = mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 7, 0,  1, 3,  0, 1);

    // Reset state
    drive(1, 3, 1, 3, 1, 1);
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_lk_valid", 32'(bus.lk_valid), 32'd0);
    check("rst_lk_cnt", 32'(bus.lk_cnt), 32'd0);
    check("rst_stall", 32'(stallreq), 32'd1);
    check("rst_ready", 32'(bus.upd_ready), 32'd0);
    check("rst_no_write", 32'(tbl_en), 32'd0);

    // Partial sweep, reset mid-INIT, then a full sweep must restart at 0
    step();
    rst = 1'b1;
    repeat (100) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    init_sweep("init");

    // Table-driven RUN vectors
    for (int i = 0; i < 10; i++) begin
      drive(int'(vt[i].lk_req), int'(vt[i].lk_idx), int'(vt[i].upd_req),
            int'(vt[i].upd_idx), int'(vt[i].old), int'(vt[i].taken));
      @(negedge clk);
      check($sformatf("v%0d_gnt", i),   32'(bus.lk_gnt),   32'(vt[i].gnt));
      check($sformatf("v%0d_en", i),    32'(tbl_en),       32'(vt[i].en));
      check($sformatf("v%0d_we", i),    32'(tbl_we),       32'(vt[i].we));
      check($sformatf("v%0d_addr", i),  32'(tbl_addr),     32'(vt[i].addr));
      check($sformatf("v%0d_wdata", i), 32'(tbl_wdata),    32'(vt[i].wdata));
      check($sformatf("v%0d_valid", i), 32'(bus.lk_valid), 32'(vt[i].valid));
      check($sformatf("v%0d_cnt", i),   32'(bus.lk_cnt),   32'(vt[i].cnt));
      check($sformatf("v%0d_taken", i), 32'(bus.lk_taken), 32'(vt[i].cnt[1]));
      check($sformatf("v%0d_stall", i), 32'(stallreq),     32'(vt[i].stall));
      check($sformatf("v%0d_ready", i), 32'(bus.upd_ready), 32'(vt[i].ready));
      step();
    end

    // Starvation: one queued update, continuous lookups -> 8 grants then forced write
    drive(0, 0, 1, 12, 2, 1);
    step();
    drive(1, 20, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("starve_gnt%0d", k), 32'(bus.lk_gnt), 32'd1);
      check($sformatf("starve_stall%0d", k), 32'(stallreq), 32'd0);
      step();
    end
    @(negedge clk);
    check("starve_force_gnt", 32'(bus.lk_gnt), 32'd0);
    check("starve_force_we", 32'(tbl_en & tbl_we), 32'd1);
    check("starve_force_addr", 32'(tbl_addr), 32'd12);
    check("starve_force_wdata", 32'(tbl_wdata), 32'd3);
    check("starve_force_stall", 32'(stallreq), 32'd1);
    step();
    @(negedge clk);
    check("starve_after_gnt", 32'(bus.lk_gnt), 32'd1);
    check("starve_after_valid", 32'(bus.lk_valid), 32'd0);
    step();

    // Duplicate indices: forwarding picks youngest, writes keep FIFO order
    drive(1, 99, 1, 60, 0, 1);
    step();
    drive(1, 99, 1, 60, 2, 1);
    step();
    drive(1, 60, 0, 0, 0, 0);
    @(negedge clk);
    check("dup_gnt", 32'(bus.lk_gnt), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("dup_fwd_valid", 32'(bus.lk_valid), 32'd1);
    check("dup_fwd_cnt", 32'(bus.lk_cnt), 32'd3);
    check("dup_wr1_addr", 32'(tbl_addr), 32'd60);
    check("dup_wr1_wdata", 32'(tbl_wdata), 32'd1);
    step();
    @(negedge clk);
    check("dup_wr2_we", 32'(tbl_en & tbl_we), 32'd1);
    check("dup_wr2_wdata", 32'(tbl_wdata), 32'd3);
    step();
    @(negedge clk);
    check("dup_empty_en", 32'(tbl_en), 32'd0);
    step();

    // Fill the queue under lookups; full queue forces a write immediately
    for (int k = 0; k < 4; k++) begin
      drive(1, 30, 1, 40 + k, k, 1);
      @(negedge clk);
      check($sformatf("fill_gnt%0d", k), 32'(bus.lk_gnt), 32'd1);
      check($sformatf("fill_ready%0d", k), 32'(bus.upd_ready), 32'd1);
      step();
    end
    drive(1, 30, 1, 50, 0, 1);
    @(negedge clk);
    check("full_gnt", 32'(bus.lk_gnt), 32'd0);
    check("full_ready", 32'(bus.upd_ready), 32'd0);
    check("full_stall", 32'(stallreq), 32'd1);
    check("full_we", 32'(tbl_en & tbl_we), 32'd1);
    check("full_addr", 32'(tbl_addr), 32'd40);
    check("full_wdata", 32'(tbl_wdata), 32'd1);
    step();
    drive(1, 30, 0, 0, 0, 0);
    @(negedge clk);
    check("after_full_gnt", 32'(bus.lk_gnt), 32'd1);
    check("after_full_ready", 32'(bus.upd_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain_we%0d", k), 32'(tbl_en & tbl_we), 32'd1);
      check($sformatf("drain_addr%0d", k), 32'(tbl_addr), 32'(40 + k));
      check($sformatf("drain_wdata%0d", k), 32'(tbl_wdata), (k == 1) ? 32'd2 : 32'd3);
      step();
    end
    @(negedge clk);
    check("drain_empty_en", 32'(tbl_en), 32'd0);
    step();

    // Reset with three queued updates: nothing written, sweep restarts at 0
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 70 + k, 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_run_no_write", 32'(tbl_en), 32'd0);
    step();
    @(negedge clk);
    check("rst_run_lk_valid", 32'(bus.lk_valid), 32'd0);
    check("rst_run_lk_cnt", 32'(bus.lk_cnt), 32'd0);
    check("rst_run_stall", 32'(stallreq), 32'd1);
    step();
    rst = 1'b1;
    init_sweep("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
